// File: rtl/fg_prog_sequencer.sv
// Floating-gate switch programming sequencer.
// Accepts one command at a time, then walks the FourTgate prog switch, the
// row/column decoders with drain select, and a train of injection pulses
// through settled phases before releasing and strobing done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command; control lines low
// MODE    | prog switch in program position, settling
// ADDR    | decoders and drain select enabled, settling
// PULSE   | injection pulse high for max(width,1) cycles
// GAP     | injection pulse low between pulses
// RELEASE | decoders/drain dropped, prog switch still held, settling
// DONE    | one-cycle completion strobe with err/aborted status

module fg_prog_sequencer #(
  parameter int ISLAND_BITS = 2,
  parameter int ROW_BITS    = 6,
  parameter int COL_BITS    = 6,
  parameter int NUM_ROWS    = 40,
  parameter int NUM_COLS    = 64,
  parameter int WIDTH_BITS  = 16,
  parameter int SETTLE      = 4,
  parameter int GAP         = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ISLAND_BITS-1:0] cmd_island,
  input  logic [ROW_BITS-1:0]    cmd_row,
  input  logic [COL_BITS-1:0]    cmd_col,
  input  logic [7:0]             cmd_pulses,
  input  logic [WIDTH_BITS-1:0]  cmd_width,
  input  logic                   abort,
  output logic [ISLAND_BITS-1:0] island_sel,
  output logic [ROW_BITS-1:0]    row_addr,
  output logic [COL_BITS-1:0]    col_addr,
  output logic                   prog_mode,
  output logic                   decode_en,
  output logic                   drain_en,
  output logic                   vinj_pulse,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   aborted,
  output logic [7:0]             pulses_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MODE    = 3'd1,
    S_ADDR    = 3'd2,
    S_PULSE   = 3'd3,
    S_GAP     = 3'd4,
    S_RELEASE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // Timer reload values: the down-counter runs N-1 .. 0, so a phase lasts N cycles.
  localparam logic [WIDTH_BITS-1:0] SETTLE_LD = WIDTH_BITS'(SETTLE - 1);
  localparam logic [WIDTH_BITS-1:0] GAP_LD    = WIDTH_BITS'(GAP - 1);

  state_t                  state_q, state_d;
  logic [WIDTH_BITS-1:0]   timer_q, timer_ld;
  logic                    tc;
  logic [ISLAND_BITS-1:0]  island_q;
  logic [ROW_BITS-1:0]     row_q;
  logic [COL_BITS-1:0]     col_q;
  logic [7:0]              pulses_q;
  logic [WIDTH_BITS-1:0]   width_q;
  logic [7:0]              pulses_done_q;
  logic [7:0]              pulses_next;
  logic                    err_q;
  logic                    aborted_q;
  logic                    range_err;
  logic                    accept;
  logic                    abortable;

  assign tc          = (timer_q == '0);
  assign accept      = (state_q == S_IDLE) && cmd_valid;
  assign range_err   = (32'(cmd_row) >= NUM_ROWS) || (32'(cmd_col) >= NUM_COLS);
  assign pulses_next = pulses_done_q + 8'd1;
  assign abortable   = (state_q == S_MODE) || (state_q == S_ADDR) ||
                       (state_q == S_PULSE) || (state_q == S_GAP);

  // State register; reset drops straight to IDLE without a release phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort in an active phase wins over timer expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = range_err ? S_DONE : S_MODE;
        end
      end
      S_MODE: begin
        if (abort)   state_d = S_RELEASE;
        else if (tc) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (abort)   state_d = S_RELEASE;
        else if (tc) state_d = (pulses_q != 8'd0) ? S_PULSE : S_RELEASE;
      end
      S_PULSE: begin
        if (abort)   state_d = S_RELEASE;
        else if (tc) state_d = (pulses_next < pulses_q) ? S_GAP : S_RELEASE;
      end
      S_GAP: begin
        if (abort)   state_d = S_RELEASE;
        else if (tc) state_d = S_PULSE;
      end
      S_RELEASE: begin
        if (tc) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Phase length for whichever state is being entered; width 0 behaves as 1.
  always_comb begin
    timer_ld = '0;
    case (state_d)
      S_MODE, S_ADDR, S_RELEASE: timer_ld = SETTLE_LD;
      S_PULSE: timer_ld = (width_q == '0) ? '0 : width_q - WIDTH_BITS'(1);
      S_GAP:   timer_ld = GAP_LD;
      default: timer_ld = '0;
    endcase
  end

  // Phase timer: reload on every state change, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else if (state_d != state_q) begin
      timer_q <= timer_ld;
    end else if (!tc) begin
      timer_q <= timer_q - WIDTH_BITS'(1);
    end
  end

  // Command latch, pulse counter and completion status.
  always_ff @(posedge clk) begin
    if (reset) begin
      island_q      <= '0;
      row_q         <= '0;
      col_q         <= '0;
      pulses_q      <= '0;
      width_q       <= '0;
      pulses_done_q <= '0;
      err_q         <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      if (accept) begin
        island_q      <= cmd_island;
        row_q         <= cmd_row;
        col_q         <= cmd_col;
        pulses_q      <= cmd_pulses;
        width_q       <= cmd_width;
        pulses_done_q <= '0;
        err_q         <= range_err;
        aborted_q     <= 1'b0;
      end
      // Only a pulse that ran its full width counts; an abort cuts it short.
      if (state_q == S_PULSE && tc) begin
        pulses_done_q <= pulses_next;
      end
      if (abortable && abort) begin
        aborted_q <= 1'b1;
      end
    end
  end

  // Control lines decoded purely from state so vinj_pulse can never outrun the decoders.
  always_comb begin
    cmd_ready  = 1'b0;
    prog_mode  = 1'b0;
    decode_en  = 1'b0;
    drain_en   = 1'b0;
    vinj_pulse = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_MODE: prog_mode = 1'b1;
      S_ADDR, S_GAP: begin
        prog_mode = 1'b1;
        decode_en = 1'b1;
        drain_en  = 1'b1;
      end
      S_PULSE: begin
        prog_mode  = 1'b1;
        decode_en  = 1'b1;
        drain_en   = 1'b1;
        vinj_pulse = 1'b1;
      end
      S_RELEASE: prog_mode = 1'b1;
      S_DONE:    done      = 1'b1;
      default: begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

  assign err         = done & err_q;
  assign aborted     = done & aborted_q;
  assign island_sel  = island_q;
  assign row_addr    = row_q;
  assign col_addr    = col_q;
  assign pulses_done = pulses_done_q;

endmodule
